// File: rtl/shufflev_instr_mem_responder.sv
// Instruction-fetch memory responder: fixed latency, bounded outstanding, preload port.
// Optional grant stalls from an LFSR when SHUFFLEV_IMEM_RANDOM_STALL_EN is defined.
module shufflev_instr_mem_responder #(
  parameter int          MEM_WORDS       = 4096,
  parameter logic [31:0] BASE_ADDR       = 32'h0010_0000,
  parameter int          LATENCY         = 2,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_wdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [32:0] END_ADDR =
    {1'b0, BASE_ADDR} + 33'(4 * MEM_WORDS);

  function automatic logic f_in_range(input logic [31:0] a);
    return (a >= BASE_ADDR) && ({1'b0, a} < END_ADDR);
  endfunction

  logic [31:0]         r_mem [MEM_WORDS];
  logic [LATENCY-1:0]  r_vld;
  logic [LATENCY-1:0]  r_err;
  logic [31:0]         r_dat [LATENCY];
  logic [CW-1:0]       r_cnt;

  logic [31:0]   w_fetch_off;
  logic [31:0]   w_load_off;
  logic [AW-1:0] w_fetch_idx;
  logic [AW-1:0] w_load_idx;
  logic          w_fetch_in;
  logic          w_load_in;
  logic          w_retire;
  logic          w_take;
  logic          w_stall;
  logic          w_unused;

  assign w_fetch_off = instr_addr_i - BASE_ADDR;
  assign w_load_off  = load_addr_i - BASE_ADDR;
  assign w_fetch_idx = w_fetch_off[AW+1:2];
  assign w_load_idx  = w_load_off[AW+1:2];
  assign w_fetch_in  = f_in_range(instr_addr_i);
  assign w_load_in   = f_in_range(load_addr_i);
  assign w_unused    = ^{w_fetch_off, w_load_off, LFSR_SEED};

`ifdef SHUFFLEV_IMEM_RANDOM_STALL_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0],
                 r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
  assign w_stall = 1'b0;
`endif

  // A response leaving the pipe this cycle frees its slot immediately.
  assign w_retire    = r_vld[LATENCY-1];
  assign instr_gnt_o = !rst_i && instr_req_i && !w_stall &&
                       ((r_cnt < CW'(MAX_OUTSTANDING)) || w_retire);
  assign w_take      = instr_req_i && instr_gnt_o;

  assign instr_rvalid_o = r_vld[LATENCY-1];
  assign instr_err_o    = r_vld[LATENCY-1] && r_err[LATENCY-1];
  assign instr_rdata_o  = r_vld[LATENCY-1] ? r_dat[LATENCY-1] : '0;
  assign outstanding_o  = r_cnt;

  // Memory holds its contents across reset.
  always_ff @(posedge clk_i) begin
    if (load_we_i && w_load_in) begin
      r_mem[w_load_idx] <= load_wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld <= '0;
      r_err <= '0;
      r_cnt <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_dat[i] <= '0;
      end
    end else begin
      r_vld[0] <= w_take;
      r_err[0] <= w_take && !w_fetch_in;
      r_dat[0] <= (w_take && w_fetch_in) ? r_mem[w_fetch_idx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_err[i] <= r_err[i-1];
        r_dat[i] <= r_dat[i-1];
      end
      r_cnt <= r_cnt + CW'(w_take) - CW'(w_retire);
    end
  end

endmodule
